// File: rtl/atualiza_aste_if.sv
// Bundles the sweep controller's start/status handshake and the asteroid-memory port.
// The master modport is the controller. The slave modport is the memory and game FSM side.
interface atualiza_aste_if;
  logic       iniciar;
  logic [9:0] mem_q;
  logic [3:0] mem_addr;
  logic [9:0] mem_data;
  logic       mem_we;
  logic       ocupado;
  logic       pronto;
  logic [4:0] ativos;
  logic       colisao;
  logic [4:0] num_colisoes;

  modport master (
    input  iniciar, mem_q,
    output mem_addr, mem_data, mem_we, ocupado, pronto, ativos, colisao, num_colisoes
  );

  modport slave (
    output iniciar, mem_q,
    input  mem_addr, mem_data, mem_we, ocupado, pronto, ativos, colisao, num_colisoes
  );
endinterface

// File: rtl/atualiza_aste.sv
// Asteroid sweep controller: one read-modify-write pass over all 16 memory entries per start.
// Each pass moves every live asteroid one step and removes those that leave the grid or hit the ship.
module atualiza_aste #(
  parameter int unsigned PASSO    = 1,
  parameter int unsigned CENTRO_X = 7,
  parameter int unsigned CENTRO_Y = 7
) (
  input logic            clk,
  input logic            reset,
  atualiza_aste_if.master bus
);

  typedef enum logic [1:0] {StIdle, StLe, StEscreve, StFim} state_e;

  localparam logic [4:0] Passo5 = 5'(PASSO);
  localparam logic [3:0] CentroX = 4'(CENTRO_X);
  localparam logic [3:0] CentroY = 4'(CENTRO_Y);

  state_e     state_q;
  logic [3:0] i_q;
  logic [4:0] cnt_q;
  logic [4:0] ativos_q;
  logic       colisao_q;
  logic [4:0] num_col_q;

  logic [3:0] x, y;
  logic [1:0] dir;
  logic [4:0] nx, ny;
  logic       empty, off, hit, origin, live, escreve;
  logic [4:0] cnt_d;

  always_comb begin
    x   = bus.mem_q[9:6];
    y   = bus.mem_q[5:2];
    dir = bus.mem_q[1:0];
    nx  = {1'b0, x};
    ny  = {1'b0, y};
    // Bit 4 of the 5-bit result is the carry/borrow that marks an off-grid move.
    unique case (dir)
      2'b00: nx = {1'b0, x} + Passo5;
      2'b01: nx = {1'b0, x} - Passo5;
      2'b10: ny = {1'b0, y} + Passo5;
      2'b11: ny = {1'b0, y} - Passo5;
      default: ;
    endcase
    empty   = (bus.mem_q == 10'd0);
    off     = nx[4] | ny[4];
    hit     = !off && (nx[3:0] == CentroX) && (ny[3:0] == CentroY);
    // (0,0) with direction 00 would read back as an empty slot, so it is dropped.
    origin  = !off && (nx[3:0] == 4'd0) && (ny[3:0] == 4'd0);
    live    = !off && !hit && !origin;
    escreve = (state_q == StEscreve);
    cnt_d   = cnt_q + {4'd0, (escreve && !empty && live)};

    bus.mem_addr     = i_q;
    bus.mem_we       = escreve && !empty;
    bus.mem_data     = (escreve && !empty && live) ? {nx[3:0], ny[3:0], dir} : 10'd0;
    bus.ocupado      = (state_q == StLe) || (state_q == StEscreve);
    bus.pronto       = (state_q == StFim);
    bus.ativos       = ativos_q;
    bus.colisao      = colisao_q;
    bus.num_colisoes = num_col_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      i_q       <= 4'd0;
      cnt_q     <= 5'd0;
      ativos_q  <= 5'd0;
      colisao_q <= 1'b0;
      num_col_q <= 5'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.iniciar) begin
            state_q   <= StLe;
            i_q       <= 4'd0;
            cnt_q     <= 5'd0;
            colisao_q <= 1'b0;
            num_col_q <= 5'd0;
          end
        end
        StLe: state_q <= StEscreve;
        StEscreve: begin
          cnt_q <= cnt_d;
          if (!empty && hit) begin
            colisao_q <= 1'b1;
            num_col_q <= num_col_q + 5'd1;
          end
          if (i_q == 4'd15) begin
            // Latch on entry to FIM so ativos is already valid while pronto is high.
            ativos_q <= cnt_d;
            state_q  <= StFim;
          end else begin
            i_q     <= i_q + 4'd1;
            state_q <= StLe;
          end
        end
        StFim: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_atualiza_aste.sv
// Randomised scoreboard bench for atualiza_aste: a behavioural model predicts writes and results.
// A negedge monitor checks the DUT against those predictions.
module tb_atualiza_aste;
  localparam int P  = 1;
  localparam int CX = 7;
  localparam int CY = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  atualiza_aste_if bus ();

  atualiza_aste #(.PASSO(P), .CENTRO_X(CX), .CENTRO_Y(CY)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory with a registered address, plus a preload path for the bench.
  logic [9:0] mem[16];
  logic [9:0] img[16];
  logic       load = 1'b0;
  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 16; k++) mem[k] <= img[k];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_data;
    end
    bus.mem_q <= mem[bus.mem_addr];
  end

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {int addr; logic [9:0] data;} wr_t;
  typedef struct {int pedge; int ativos; int col; int ncol;} res_t;
  wr_t  wq[$];
  res_t rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] ref_mem[16];
  logic [9:0] old_mem[16];

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // kind: 0 empty, 1 removed, 2 hit ship, 3 still alive
  function automatic logic [9:0] step(input logic [9:0] e, output int kind);
    int x, y;
    x = int'(e[9:6]);
    y = int'(e[5:2]);
    if (e == 10'd0) begin kind = 0; return 10'd0; end
    case (e[1:0])
      2'b00: x = x + P;
      2'b01: x = x - P;
      2'b10: y = y + P;
      default: y = y - P;
    endcase
    if (x < 0 || x > 15 || y < 0 || y > 15) begin kind = 1; return 10'd0; end
    if (x == CX && y == CY) begin kind = 2; return 10'd0; end
    if (x == 0 && y == 0) begin kind = 1; return 10'd0; end
    kind = 3;
    return {4'(x), 4'(y), e[1:0]};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_addr", int'(bus.mem_addr), w.addr);
          chk("write_data", int'(bus.mem_data), int'(w.data));
        end
      end
      if (bus.pronto) begin
        if (rq.size() == 0) chk("unexpected_pronto", 1, 0);
        else begin
          res_t r;
          r = rq.pop_front();
          chk("pronto_cycle", edges, r.pedge);
          chk("ativos", int'(bus.ativos), r.ativos);
          chk("colisao", int'(bus.colisao), r.col);
          chk("num_colisoes", int'(bus.num_colisoes), r.ncol);
        end
      end
    end
  end

  task automatic load_mem();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 16; k++) ref_mem[k] = img[k];
  endtask

  task automatic check_mem(input string name);
    for (int k = 0; k < 16; k++) chk(name, int'(mem[k]), int'(ref_mem[k]));
  endtask

  // mode: 0 plain, 1 extra iniciar mid-sweep, 2 reset during entry 5's read cycle
  task automatic run_sweep(input int mode);
    int kind, live, hits, e0;
    logic [9:0] nv[16];
    @(posedge clk);
    #1 bus.iniciar = 1'b1;
    @(posedge clk);
    #1 bus.iniciar = 1'b0;
    e0 = edges;
    live = 0;
    hits = 0;
    for (int k = 0; k < 16; k++) begin
      nv[k] = step(ref_mem[k], kind);
      if (kind != 0) wq.push_back('{addr: k, data: nv[k]});
      if (kind == 3) live++;
      if (kind == 2) hits++;
      old_mem[k] = ref_mem[k];
      ref_mem[k] = nv[k];
    end
    rq.push_back('{pedge: e0 + 32, ativos: live, col: (hits > 0) ? 1 : 0, ncol: hits});
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (mode == 2 && c == 12) begin
        chk("rst_mem_we", int'(bus.mem_we), 0);
        chk("rst_ocupado", int'(bus.ocupado), 0);
        chk("rst_pronto", int'(bus.pronto), 0);
        chk("rst_ativos", int'(bus.ativos), 0);
        chk("rst_colisao", int'(bus.colisao), 0);
        chk("rst_num_colisoes", int'(bus.num_colisoes), 0);
        reset = 1'b0;
        wq.delete();
        rq.delete();
        for (int k = 5; k < 16; k++) ref_mem[k] = old_mem[k];
        check_mem("rst_mem");
        return;
      end
      chk("ocupado", int'(bus.ocupado), (c <= 32) ? 1 : 0);
      if (mode == 1 && c == 9) bus.iniciar = 1'b1;
      if (mode == 1 && c == 10) bus.iniciar = 1'b0;
      if (mode == 2 && c == 11) reset = 1'b1;
    end
    chk("writes_left", wq.size(), 0);
    chk("pronto_missing", rq.size(), 0);
    wq.delete();
    rq.delete();
    check_mem("mem");
  endtask

  initial begin
    reset = 1'b1;
    bus.iniciar = 1'b0;
    for (int k = 0; k < 16; k++) img[k] = 10'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_addr", int'(bus.mem_addr), 0);
    chk("reset_mem_data", int'(bus.mem_data), 0);
    chk("reset_mem_we", int'(bus.mem_we), 0);
    chk("reset_ocupado", int'(bus.ocupado), 0);
    chk("reset_pronto", int'(bus.pronto), 0);
    chk("reset_ativos", int'(bus.ativos), 0);
    chk("reset_colisao", int'(bus.colisao), 0);
    chk("reset_num_colisoes", int'(bus.num_colisoes), 0);
    reset = 1'b0;

    // Single asteroid walking down onto the ship cell.
    img[0] = 10'b0111_1110_11;
    load_mem();
    run_sweep(0);
    chk("walk_first_step", int'(mem[0]), int'(10'b0111_1101_11));
    for (int s = 0; s < 6; s++) run_sweep(0);
    chk("walk_final_entry", int'(mem[0]), 0);
    chk("walk_colisao", int'(bus.colisao), 1);
    chk("walk_num_colisoes", int'(bus.num_colisoes), 1);

    // Off-grid removal on both edges.
    for (int k = 0; k < 16; k++) img[k] = 10'd0;
    img[3] = 10'b0000_0111_01;
    img[4] = 10'b1111_0011_00;
    load_mem();
    run_sweep(0);

    // All empty, then full load.
    for (int k = 0; k < 16; k++) img[k] = 10'd0;
    load_mem();
    run_sweep(0);
    for (int k = 0; k < 16; k++) img[k] = 10'b0111_0000_10;
    load_mem();
    run_sweep(0);
    chk("full_ativos", int'(bus.ativos), 16);

    // Random sweeps, some with a spurious start mid-sweep.
    for (int s = 0; s < 20; s++) begin
      for (int k = 0; k < 16; k++)
        img[k] = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom);
      img[$urandom_range(0, 15)] = {4'(CX), 4'(CY + 1), 2'b11};
      load_mem();
      run_sweep((s % 3 == 0) ? 1 : 0);
      if (s % 4 == 0) run_sweep(0);
    end

    // Reset in the middle of a sweep.
    for (int k = 0; k < 16; k++) img[k] = 10'($urandom) | 10'b0000_1000_00;
    load_mem();
    run_sweep(2);
    run_sweep(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
